// File: rtl/aes_fpga_pkg.sv
// rtl/aes_fpga_pkg.sv - shared FSM states, ASCII constants and helpers for the AES result UART path
package aes_fpga_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } tx_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_NEXT_CHAR,
    SEQ_FINISH
  } seq_state_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h57;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         HEX_CHARS   = 32;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_OFS + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with per-bit baud counter
// byte_ready also rises on the last stop-bit clock so consecutive bytes leave no gap.
module uart_tx_byte
  import aes_fpga_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          bit_end;

  always_comb begin
    bit_end    = (baud_q == BAUD_LAST);
    baud_d     = bit_end ? '0 : baud_q + CW'(1);
    byte_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP_BIT) && bit_end);
  end

  assign tx = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= baud_d;
      unique case (state_q)
        TX_IDLE: begin
          baud_q <= '0;
          if (byte_valid) begin
            shreg_q <= byte_data;
            tx_q    <= 1'b0;
            state_q <= TX_START_BIT;
          end
        end
        TX_START_BIT: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
            bit_q   <= '0;
            state_q <= TX_DATA_BITS;
          end
        end
        TX_DATA_BITS: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP_BIT;
            end else begin
              tx_q    <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        TX_STOP_BIT: begin
          if (bit_end) begin
            if (byte_valid) begin
              shreg_q <= byte_data;
              tx_q    <= 1'b0;
              state_q <= TX_START_BIT;
            end else begin
              state_q <= TX_IDLE;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_result_uart_tx.sv
// rtl/aes_result_uart_tx.sv - sends a 128-bit AES block as 32 lowercase hex chars over 8N1 UART
// Define AES_TX_CRLF_EN to append CR LF after the hex characters.
module aes_result_uart_tx
  import aes_fpga_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
`ifdef AES_TX_CRLF_EN
  localparam int NUM_CHARS = HEX_CHARS + 2;
`else
  localparam int NUM_CHARS = HEX_CHARS;
`endif
  localparam logic [5:0] LAST_CHAR = 6'(NUM_CHARS - 1);

  seq_state_e   state_q;
  logic [127:0] shift_q, shift_d;
  logic [5:0]   char_idx_q, char_idx_d;
  logic         busy_q, done_q;
  logic         byte_valid, byte_ready;
  logic [7:0]   byte_data;
  logic [3:0]   nibble;

  // Char 0 is taken straight from the input so the start bit begins the cycle after start.
  always_comb begin
    nibble     = (state_q == SEQ_IDLE) ? data[127:124] : shift_q[127:124];
    byte_data  = hex_ascii(nibble);
`ifdef AES_TX_CRLF_EN
    if (state_q != SEQ_IDLE && char_idx_q == 6'(HEX_CHARS))
      byte_data = ASCII_CR;
    else if (state_q != SEQ_IDLE && char_idx_q == 6'(HEX_CHARS + 1))
      byte_data = ASCII_LF;
`endif
    byte_valid = (state_q == SEQ_IDLE) ? start : (state_q == SEQ_NEXT_CHAR);
    shift_d    = (state_q == SEQ_IDLE) ? {data[123:0], 4'h0} : {shift_q[123:0], 4'h0};
    char_idx_d = char_idx_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      shift_q    <= '0;
      char_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            shift_q    <= shift_d;
            char_idx_q <= 6'd1;
            busy_q     <= 1'b1;
            state_q    <= SEQ_NEXT_CHAR;
          end
        end
        SEQ_NEXT_CHAR: begin
          if (byte_ready) begin
            shift_q    <= shift_d;
            char_idx_q <= char_idx_d;
            if (char_idx_q == LAST_CHAR) state_q <= SEQ_FINISH;
          end
        end
        SEQ_FINISH: begin
          // Serializer is ready here only as the last stop bit ends.
          if (byte_ready) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            char_idx_q <= '0;
            state_q    <= SEQ_IDLE;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (tx)
  );

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// tb/tb_aes_result_uart_tx.sv - directed bench for aes_result_uart_tx (1.25 MHz / 100 kbaud -> 12 clocks per bit)
module tb_aes_result_uart_tx;

  localparam int CPB = 12;
`ifdef AES_TX_CRLF_EN
  localparam int NCH = 34;
`else
  localparam int NCH = 32;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done, tx;
  logic [127:0] data;
  int           n_assert = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  aes_result_uart_tx #(
    .CLK_HZ(1_250_000),
    .BAUD  (100_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .busy (busy),
    .done (done),
    .tx   (tx)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input string s, input int k);
    if (k < 32) return s[k];
    else if (k == 32) return 8'h0D;
    else return 8'h0A;
  endfunction

  // Accepts a block, then checks tx on every clock against the ideal 8N1 waveform,
  // decodes each char at mid-bit and checks the done cycle.
  task automatic send_msg(input string tag, input logic [127:0] d, input string s, input int t_intr);
    logic [7:0] rx[NCH];
    logic [7:0] sh;
    logic [7:0] c;
    logic       e;
    int         bad_tx, bad_ctl, k, j, ph;
    bad_tx  = 0;
    bad_ctl = 0;
    sh      = 8'h00;
    data    = d;
    start   = 1'b1;
    tick;
    start = 1'b0;
    chk($sformatf("%s busy_rise", tag), busy, 1);
    chk($sformatf("%s first_start_bit", tag), tx, 0);
    for (int t = 0; t < NCH * 10 * CPB; t++) begin
      k  = t / (10 * CPB);
      j  = (t / CPB) % 10;
      ph = t % CPB;
      c  = exp_char(s, k);
      e  = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : c[j-1];
      if (tx !== e) bad_tx++;
      if (busy !== 1'b1 || done !== 1'b0) bad_ctl++;
      if (ph == CPB / 2 && j >= 1 && j <= 8) sh = {tx, sh[7:1]};
      if (ph == CPB / 2 && j == 8) rx[k] = sh;
      start = (t == t_intr);
      if (t == t_intr) data = ~d;
      tick;
    end
    start = 1'b0;
    chk($sformatf("%s tx_waveform_errors", tag), bad_tx, 0);
    chk($sformatf("%s busy_done_errors", tag), bad_ctl, 0);
    for (int i = 0; i < NCH; i++) chk($sformatf("%s char%0d", tag, i), rx[i], exp_char(s, i));
    chk($sformatf("%s done_pulse", tag), done, 1);
    chk($sformatf("%s busy_fall", tag), busy, 0);
    chk($sformatf("%s tx_idle_at_done", tag), tx, 1);
  endtask

  initial begin
    int bad;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    tick;
    tick;
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    tick;
    chk("idle tx", tx, 1);
    chk("idle busy", busy, 0);

    // Reset during bit 3 of char 5 ('0' = 8'h30, bit 3 = 0)
    data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (54 * CPB + 3) tick;
    chk("midrst pre tx", tx, 0);
    chk("midrst pre busy", busy, 1);
    rst = 1'b1;
    tick;
    chk("midrst tx", tx, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (30 * CPB) begin
      tick;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("midrst stays idle", bad, 0);

    send_msg("t2", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "69c4e0d86a7b0430d8cdb78070b4c55a", -1);
    tick;
    chk("t2 done_one_cycle", done, 0);
    chk("t2 idle_busy", busy, 0);

    send_msg("t3", 128'h0, "00000000000000000000000000000000", 100 * CPB + 5);
    tick;
    chk("t3 no_queued_start", busy, 0);
    chk("t3 no_queued_tx", tx, 1);

    // Second start lands in the done cycle of the first
    send_msg("t4a", 128'h00112233445566778899aabbccddeeff, "00112233445566778899aabbccddeeff", -1);
    send_msg("t4b", 128'h00112233445566778899aabbccddeeff, "00112233445566778899aabbccddeeff", -1);
    tick;
    chk("t4 done_one_cycle", done, 0);

    send_msg("t6", {128{1'b1}}, "ffffffffffffffffffffffffffffffff", -1);
    tick;
    chk("t6 final_idle", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
